// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REQ, REFILL, DRAIN} state_t;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(input int num_lines, input int line_words);
    return 30 - $clog2(line_words) - $clog2(num_lines);
  endfunction

  // Clears the byte and word-offset bits so the result points at the first word of the line.
  function automatic logic [31:0] line_addr(input logic [31:0] addr, input int line_words);
    logic [31:0] mask;
    mask = (32'(line_words) << 2) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill controller: owns the state, beat counter, latched line address and memory handshake,
// and tells the cache top which word of the refill line to write.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss,
  input  logic                          flush,
  input  logic [31:0]                   pc,
  input  logic                          mem_ack,
  input  logic                          mem_rvalid,
  output state_t                        state,
  output logic                          mem_req,
  output logic [31:0]                   mem_addr,
  output logic                          wr_en,
  output logic [$clog2(LINE_WORDS)-1:0] wr_word,
  output logic                          wr_last,
  output logic                          drop
);

  localparam int OB = offset_bits(LINE_WORDS);

  state_t        state_nx;
  logic [OB-1:0] cnt;
  logic [OB-1:0] cnt_nx;
  logic          last_beat;

  assign last_beat = (cnt == OB'(LINE_WORDS - 1));
  assign wr_word   = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_addr <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && miss)
        mem_addr <= line_addr(pc, LINE_WORDS);
    end
  end

  // A flush while the line is in flight suppresses its writes; the remaining beats are drained.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mem_req  = 1'b0;
    wr_en    = 1'b0;
    wr_last  = 1'b0;
    drop     = flush && (state != DRAIN);
    case (state)
      IDLE: begin
        if (miss)
          state_nx = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_nx = REFILL;
          cnt_nx   = '0;
        end
      end
      REFILL: begin
        if (mem_rvalid) begin
          cnt_nx  = cnt + 1'b1;
          wr_en   = !flush;
          wr_last = !flush && last_beat;
        end
        if (mem_rvalid && last_beat)
          state_nx = IDLE;
        else if (flush)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (mem_rvalid) begin
          cnt_nx = cnt + 1'b1;
          if (last_beat)
            state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with register arrays and combinational lookup.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        fetch_en,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall_fetch,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int OB    = offset_bits(LINE_WORDS);
  localparam int IB    = index_bits(NUM_LINES);
  localparam int TAG_W = tag_bits(NUM_LINES, LINE_WORDS);

  logic [31:0]      data_arr [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_arr  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  logic [OB-1:0]    offset;
  logic [IB-1:0]    index;
  logic [TAG_W-1:0] tag;
  logic [IB-1:0]    ridx;
  logic [TAG_W-1:0] rtag;
  logic             hit;
  logic             miss;
  state_t           state;
  logic             wr_en;
  logic [OB-1:0]    wr_word;
  logic             wr_last;
  logic             drop;
  logic             unused_bits;

  assign offset      = pcF[2 +: OB];
  assign index       = pcF[2+OB +: IB];
  assign tag         = pcF[31 -: TAG_W];
  assign ridx        = mem_addr[2+OB +: IB];
  assign rtag        = mem_addr[31 -: TAG_W];
  assign unused_bits = ^{pcF[1:0], mem_addr[1+OB:0]};

  assign hit         = fetch_en && valid[index] && (tag_arr[index] == tag) && (state == IDLE);
  assign miss        = fetch_en && !hit && (state == IDLE);
  assign instr_valid = hit;
  assign instr       = hit ? data_arr[index][offset] : 32'd0;
  assign stall_fetch = (state != IDLE) || miss;

  icache_refill_fsm #(
    .LINE_WORDS(LINE_WORDS)
  ) u_refill (
    .clk       (clk),
    .rst       (rst),
    .miss      (miss),
    .flush     (flush),
    .pc        (pcF),
    .mem_ack   (mem_ack),
    .mem_rvalid(mem_rvalid),
    .state     (state),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .wr_en     (wr_en),
    .wr_word   (wr_word),
    .wr_last   (wr_last),
    .drop      (drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      valid <= '0;
    else if (drop)
      valid <= '0;
    else if (wr_last)
      valid[ridx] <= 1'b1;
  end

  // Data and tag storage is deliberately unreset; the valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (wr_en)
      data_arr[ridx][wr_word] <= mem_rdata;
    if (wr_last)
      tag_arr[ridx] <= rtag;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit)
        hit_count <= hit_count + 32'd1;
      if (miss)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct (default 16 lines x 4 words).
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        fetch_en;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall_fetch;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks;
  int errors;

  icache_direct dut (
    .clk        (clk),
    .rst        (rst),
    .pcF        (pcF),
    .fetch_en   (fetch_en),
    .flush      (flush),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall_fetch(stall_fetch),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic [31:0] pc, input logic fl,
                               input logic ack, input logic rv, input logic [31:0] rd);
    fetch_en   = fe;
    pcF        = pc;
    flush      = fl;
    mem_ack    = ack;
    mem_rvalid = rv;
    mem_rdata  = rd;
    #1;
  endtask

  // Starts in REQ: acks at once, then plays the beat pattern (bit i = beat on cycle i).
  task automatic refillLine(input logic [31:0] base, input logic [15:0] pat, input int plen);
    int beat;
    beat = 0;
    mem_ack = 1'b1;
    #1;
    tick;
    mem_ack = 1'b0;
    for (int i = 0; i < plen; i++) begin
      mem_rvalid = pat[i];
      mem_rdata  = pat[i] ? base + 32'(beat) : 32'hDEAD_BEEF;
      if (pat[i]) beat++;
      #1;
      checkOutput("refill_stall", {31'd0, stall_fetch}, 32'd1);
      tick;
    end
    mem_rvalid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("rst_stall", {31'd0, stall_fetch}, 32'd0);
    checkOutput("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    rst = 1'b0;

    // Cold miss at 0x40 with the ack two cycles late.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("cold_stall", {31'd0, stall_fetch}, 32'd1);
    checkOutput("cold_ivalid", {31'd0, instr_valid}, 32'd0);
    checkOutput("cold_noreq", {31'd0, mem_req}, 32'd0);
    tick;
    checkOutput("cold_req", {31'd0, mem_req}, 32'd1);
    checkOutput("cold_addr", mem_addr, 32'h40);
    tick;
    checkOutput("cold_req_hold", {31'd0, mem_req}, 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
    tick;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'hA0 + 32'(i));
      checkOutput("cold_beat_stall", {31'd0, stall_fetch}, 32'd1);
      tick;
    end
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("cold_hit_instr", instr, 32'hA0);
    checkOutput("cold_hit_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("cold_hit_stall", {31'd0, stall_fetch}, 32'd0);
    checkOutput("cold_hit_noreq", {31'd0, mem_req}, 32'd0);

    // Same-line hits.
    applyStimulus(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("hit_4c", instr, 32'hA3);
    checkOutput("hit_4c_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("hit_4c_noreq", {31'd0, mem_req}, 32'd0);
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("hit_48", instr, 32'hA2);

    // Conflict eviction: 0x140 shares index 4 with 0x40.
    applyStimulus(1'b1, 32'h140, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("conf_stall", {31'd0, stall_fetch}, 32'd1);
    checkOutput("conf_ivalid", {31'd0, instr_valid}, 32'd0);
    tick;
    checkOutput("conf_addr", mem_addr, 32'h140);
    checkOutput("conf_req", {31'd0, mem_req}, 32'd1);
    refillLine(32'hB0, 16'h000F, 4);
    applyStimulus(1'b1, 32'h140, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("conf_hit", instr, 32'hB0);
    checkOutput("conf_hit_valid", {31'd0, instr_valid}, 32'd1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("evict_ivalid", {31'd0, instr_valid}, 32'd0);
    checkOutput("evict_stall", {31'd0, stall_fetch}, 32'd1);
    tick;
    checkOutput("evict_addr", mem_addr, 32'h40);

    // Gapped beats 1,0,0,1,1,0,1.
    refillLine(32'hA0, 16'h0059, 7);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("gap_w0", instr, 32'hA0);
    checkOutput("gap_stall", {31'd0, stall_fetch}, 32'd0);
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("gap_w1", instr, 32'hA1);
    applyStimulus(1'b1, 32'h48, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("gap_w2", instr, 32'hA2);
    applyStimulus(1'b1, 32'h4C, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("gap_w3", instr, 32'hA3);

    // Flush after beat 1 of a refill of 0x80.
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("fl_stall", {31'd0, stall_fetch}, 32'd1);
    tick;
    checkOutput("fl_addr", mem_addr, 32'h80);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'hC0);
    tick;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'hC1);
    tick;
    applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("fl_pulse_stall", {31'd0, stall_fetch}, 32'd1);
    tick;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'hC2);
    checkOutput("drain_stall2", {31'd0, stall_fetch}, 32'd1);
    checkOutput("drain_ivalid", {31'd0, instr_valid}, 32'd0);
    tick;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b1, 32'hC3);
    checkOutput("drain_stall3", {31'd0, stall_fetch}, 32'd1);
    tick;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("drain_miss_ivalid", {31'd0, instr_valid}, 32'd0);
    checkOutput("drain_miss_stall", {31'd0, stall_fetch}, 32'd1);
    tick;
    checkOutput("drain_rereq", {31'd0, mem_req}, 32'd1);
    checkOutput("drain_readdr", mem_addr, 32'h80);
    refillLine(32'hD0, 16'h000F, 4);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("refetch_hit", instr, 32'hD0);

    // Flush in IDLE: hit still served in the flush cycle, then the line misses.
    applyStimulus(1'b1, 32'h84, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("idle_fl_instr", instr, 32'hD1);
    checkOutput("idle_fl_valid", {31'd0, instr_valid}, 32'd1);
    tick;
    applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("idle_fl_miss", {31'd0, instr_valid}, 32'd0);
    checkOutput("idle_fl_stall", {31'd0, stall_fetch}, 32'd1);
    tick;
    checkOutput("idle_fl_addr", mem_addr, 32'h80);

    // Async reset in the middle of a refill.
    applyStimulus(1'b1, 32'h84, 1'b0, 1'b1, 1'b0, 32'h0);
    tick;
    applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 1'b1, 32'hE0);
    tick;
    applyStimulus(1'b0, 32'h84, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("refill_nofetch_stall", {31'd0, stall_fetch}, 32'd1);
`ifdef ICACHE_STATS_EN
    checkOutput("stats_miss_pre", miss_count, 32'd6);
`endif
    rst = 1'b1;
    #1;
    checkOutput("arst_req", {31'd0, mem_req}, 32'd0);
    checkOutput("arst_stall", {31'd0, stall_fetch}, 32'd0);
    checkOutput("arst_ivalid", {31'd0, instr_valid}, 32'd0);
    checkOutput("arst_addr", mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
    checkOutput("stats_hit_rst", hit_count, 32'd0);
    checkOutput("stats_miss_rst", miss_count, 32'd0);
`endif
    rst = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h84, 1'b0, 1'b0, 1'b1, 32'hF0 + 32'(i));
      checkOutput("stray_noreq", {31'd0, mem_req}, 32'd0);
      tick;
    end
    applyStimulus(1'b1, 32'h84, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post_rst_miss", {31'd0, instr_valid}, 32'd0);
    checkOutput("post_rst_stall", {31'd0, stall_fetch}, 32'd1);
    tick;
    checkOutput("post_rst_req", {31'd0, mem_req}, 32'd1);
    checkOutput("post_rst_addr", mem_addr, 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the core's fetch port (pcF in, instr out) and a word-wide backing instruction memory.
- Hits return the instruction in the same cycle; the fetch stage never waits on a hit.
- A miss raises stall_fetch and runs a fixed-length line refill burst, then releases fetch.
- Arrays are register-based so lookup is combinational on pcF.

Parameters:
NUM_LINES, 16, number of cache lines (power of 2, ≥2)
LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
pcF  in  32  fetch address; bits [1:0] ignored
fetch_en  in  1  core requests an instruction this cycle
flush  in  1  invalidate all lines (single-cycle pulse)
instr  out  32  instruction for pcF, valid when instr_valid=1
instr_valid  out  1  hit this cycle
stall_fetch  out  1  core must hold pcF
mem_req  out  1  refill request to backing memory
mem_addr  out  32  line-aligned refill base address
mem_ack  in  1  memory accepts request (mem_req && mem_ack = handshake)
mem_rdata  in  32  refill data beat
mem_rvalid  in  1  beat valid; beats arrive in ascending word order

Behaviour:
- Address split: offset = pcF[2+:log2(LINE_WORDS)], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
- Hit = fetch_en && valid[index] && tag_arr[index]==tag && state==IDLE. On hit: instr = data[index][offset], instr_valid=1, stall_fetch=0, same cycle.
- Miss (fetch_en && !hit in IDLE): stall_fetch=1 combinationally the same cycle; next state REQ.
- fetch_en=0: instr_valid=0, stall_fetch=0, no state change.
- States:
  - IDLE: lookup.
  - REQ: mem_req=1, mem_addr = {pcF[31:2+log2(LINE_WORDS)], zeros}, registered on miss entry. Hold until mem_ack; then REFILL with beat counter=0.
  - REFILL: each mem_rvalid writes mem_rdata to data[idx][cnt], cnt++. On beat LINE_WORDS-1: write tag, set valid, go IDLE. The next cycle hits and releases stall.
  - DRAIN: accept and discard remaining beats; no valid/tag update; after the last beat, go IDLE.
- stall_fetch=1 in REQ, REFILL and DRAIN regardless of fetch_en. instr_valid=0 there.
- Miss penalty is minimum 1 (REQ) + LINE_WORDS beat cycles, then a hit cycle.
- mem_rvalid outside REFILL/DRAIN is ignored.
- Beat gaps: the counter holds while mem_rvalid=0.
- flush:
  - In IDLE or REQ: clears all valid bits next edge. A hit lookup in the flush cycle still returns data.
  - In REQ the request proceeds; the refilled line becomes valid.
  - In REFILL: all valid bits cleared; FSM goes to DRAIN (the in-flight line never becomes valid).
  - In DRAIN: no further effect.
- The core must hold pcF stable while stall_fetch=1; the cache uses the latched refill address, not pcF, during refill.
- Reset: state=IDLE, all valid=0, cnt=0, mem_req=0, mem_addr=0, instr=0 (driven 0 when !instr_valid), instr_valid=0, stall_fetch=0. Data/tag arrays are not reset.
- Reset mid-refill aborts immediately. Outstanding memory beats after reset are ignored (IDLE ignores mem_rvalid).

Optional Feature:
ICACHE_STATS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each hit cycle; miss_count increments on each IDLE→REQ transition.
  - Both wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package icache_pkg:
  - state enum {IDLE, REQ, REFILL, DRAIN}.
  - localparam functions for offset/index/tag widths derived from NUM_LINES/LINE_WORDS.
  - Line-address helper (zero the offset bits).
- One sub-module icache_refill_fsm: owns state, beat counter, latched refill address, and the mem_* handshake. Emits line-write strobes (wr_en, wr_word, wr_last, drop) to the top, which holds the tag/valid/data arrays and the hit logic.

Test Plan:
- Cold miss: reset, fetch_en=1, pcF=0x0000_0040. stall_fetch=1 same cycle; mem_req with mem_addr=0x40. Ack after 2 cycles, beats 0xA0..0xA3 back-to-back. Next cycle instr=0xA0, instr_valid=1, stall_fetch=0.
- Same-line hit: after the above, pcF=0x4C → instr=0xA3 same cycle, no mem_req. pcF=0x48 → 0xA2.
- Conflict eviction (defaults): fill 0x40, then fetch 0x140 (same index, tag differs). Expect miss and refill with mem_addr=0x140; refetch 0x40 misses again.
- Gapped beats: mem_rvalid pattern 1,0,0,1,1,0,1. All four words land in order; stall held until the cycle after the 4th beat.
- Flush mid-refill: assert flush after beat 1. Remaining 2 beats drained; next fetch of the same pcF misses and re-requests. Separately, a flush in IDLE makes previously hit lines miss.
- Async reset during REFILL: rst pulse between edges. mem_req, stall_fetch and instr_valid go to 0 immediately; stray mem_rvalid after reset writes nothing (next fetch misses). With ICACHE_STATS_EN, hit_count/miss_count read 0 after reset.
